operand_fetch: RTL and testbench



---
 rtl/operand_fetch.sv | 159 +++++++++++++++
 tb/tb_operand_fetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage directly upstream of Execute.
// It queues instruction words from fetch in a small FIFO and reads two
// operands from an internal 8-entry register file. It then presents
// IR/T1/T2/carry to Execute under a valid/ready handshake and waits for
// Execute's writeback before it issues the next instruction. Only one
// instruction is in flight past this stage at any time.
//
// Ports:
//   i_w_clk        clock, rising edge
//   i_w_reset      asynchronous, active-low reset
//   i_instr        instruction word from fetch
//   i_instr_valid  i_instr valid (push when o_instr_ready)
//   o_instr_ready  queue can accept a word (queue not full)
//   o_ir           instruction word presented to Execute
//   o_t1           R[rd], where rd = ir[15:13]
//   o_t2           R[rs], where rs = ir[12:10]
//   o_carry        carry flag presented to Execute
//   o_valid        o_ir/o_t1/o_t2/o_carry valid
//   i_ready        Execute accepts the current operands
//   i_wb_data      writeback result for R[rd]
//   i_wb_carry     writeback carry flag
//   i_wb_valid     writeback strobe (used only while waiting for writeback)
//   o_busy         an instruction is in flight or the queue is non-empty
module operand_fetch #(
  parameter int unsigned p_data_width = 16,
  parameter int unsigned p_fifo_depth = 2
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic [p_data_width-1:0] i_instr,
  input  logic                    i_instr_valid,
  output logic                    o_instr_ready,
  output logic [p_data_width-1:0] o_ir,
  output logic [p_data_width-1:0] o_t1,
  output logic [p_data_width-1:0] o_t2,
  output logic                    o_carry,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic [p_data_width-1:0] i_wb_data,
  input  logic                    i_wb_carry,
  input  logic                    i_wb_valid,
  output logic                    o_busy
);

  localparam int unsigned PW     = $clog2(p_fifo_depth);
  localparam int unsigned CW     = $clog2(p_fifo_depth + 1);
  localparam int unsigned RD_LSB = p_data_width - 3;
  localparam int unsigned RS_LSB = p_data_width - 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_WB
  } state_t;

  state_t                  state;
  logic [p_data_width-1:0] q_mem [p_fifo_depth];
  logic [PW-1:0]           q_head;
  logic [PW-1:0]           q_tail;
  logic [CW-1:0]           q_count;
  logic [p_data_width-1:0] regs [8];
  logic                    flag;
  logic [2:0]              rd_q;

  logic                    q_full;
  logic                    q_empty;
  logic                    push;
  logic                    pop;
  logic [p_data_width-1:0] head_word;
  logic [2:0]              head_rd;
  logic [2:0]              head_rs;
  logic [p_data_width-1:0] rd_val;
  logic [p_data_width-1:0] rs_val;

  assign q_full        = (q_count == CW'(p_fifo_depth));
  assign q_empty       = (q_count == '0);
  assign o_instr_ready = !q_full;
  assign push          = i_instr_valid && !q_full;
  // Only the registered queue is popped, so a word pushed at an edge is
  // never issued at that same edge.
  assign pop           = (state == IDLE) && !q_empty;
  assign o_busy        = (state != IDLE) || !q_empty;

  assign head_word = q_mem[q_head];
  assign head_rd   = head_word[RD_LSB +: 3];
  assign head_rs   = head_word[RS_LSB +: 3];

  // R0 always reads as zero; the array entry is never written.
  always_comb begin
    rd_val = (head_rd == 3'd0) ? '0 : regs[head_rd];
    rs_val = (head_rs == 3'd0) ? '0 : regs[head_rs];
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state   <= IDLE;
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
      for (int unsigned i = 0; i < p_fifo_depth; i++) begin
        q_mem[i] <= '0;
      end
      for (int unsigned i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      flag    <= 1'b0;
      rd_q    <= '0;
      o_ir    <= '0;
      o_t1    <= '0;
      o_t2    <= '0;
      o_carry <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (push) begin
        q_mem[q_tail] <= i_instr;
        q_tail        <= q_tail + 1'b1;
      end
      if (pop) begin
        q_head <= q_head + 1'b1;
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            o_ir    <= head_word;
            o_t1    <= rd_val;
            o_t2    <= rs_val;
            o_carry <= flag;
            rd_q    <= head_rd;
            o_valid <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= WAIT_WB;
          end
        end
        WAIT_WB: begin
          if (i_wb_valid) begin
            if (rd_q != 3'd0) begin
              regs[rd_q] <= i_wb_data;
            end
            flag  <= i_wb_carry;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch. It keeps a behavioural model of
// the architectural register file and carry flag. Expected operands are
// derived from the instruction fields and from the writebacks the bench
// has issued.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] ir;
  logic [15:0] t1;
  logic [15:0] t2;
  logic        carry;
  logic        valid;
  logic        ready;
  logic [15:0] wb_data;
  logic        wb_carry;
  logic        wb_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] mregs [8];
  logic        mflag;

  operand_fetch #(.p_data_width(16), .p_fifo_depth(2)) dut (
    .i_w_clk       (clk),
    .i_w_reset     (rst_n),
    .i_instr       (instr),
    .i_instr_valid (instr_valid),
    .o_instr_ready (instr_ready),
    .o_ir          (ir),
    .o_t1          (t1),
    .o_t2          (t2),
    .o_carry       (carry),
    .o_valid       (valid),
    .i_ready       (ready),
    .i_wb_data     (wb_data),
    .i_wb_carry    (wb_carry),
    .i_wb_valid    (wb_valid),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    mflag = 1'b0;
  endtask

  // Operands the architecture defines for a given instruction word.
  task automatic expect_issue(input string tag, input logic [15:0] word);
    logic [2:0] rd;
    logic [2:0] rs;
    rd = word[15:13];
    rs = word[12:10];
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk({tag, "_ir"}, {16'd0, ir}, {16'd0, word});
    chk({tag, "_t1"}, {16'd0, t1}, {16'd0, mregs[rd]});
    chk({tag, "_t2"}, {16'd0, t2}, {16'd0, mregs[rs]});
    chk({tag, "_carry"}, {31'd0, carry}, {31'd0, mflag});
  endtask

  // Holds off Execute for 'delay' cycles, then accepts the operands.
  task automatic accept(input logic [15:0] word, input int delay);
    for (int d = 0; d < delay; d++) begin
      step();
      expect_issue("hold", word);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("accept_valid_low", {31'd0, valid}, 32'd0);
    chk("accept_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic writeback(input logic [15:0] word, input logic [15:0] data, input logic c);
    wb_valid = 1'b1;
    wb_data  = data;
    wb_carry = c;
    step();
    wb_valid = 1'b0;
    if (word[15:13] != 3'd0) mregs[word[15:13]] = data;
    mflag = c;
  endtask

  task automatic run_instr(input logic [15:0] word, input logic [15:0] data,
                           input logic c, input int delay);
    instr       = word;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("latency_not_yet", {31'd0, valid}, 32'd0);
    step();
    expect_issue("issue", word);
    accept(word, delay);
    writeback(word, data, c);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] w3;
    logic [15:0] wa;
    rst_n       = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    ready       = 1'b0;
    wb_data     = 16'h0000;
    wb_carry    = 1'b0;
    wb_valid    = 1'b0;
    model_reset();

    // Reset values
    #12;
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_t1", {16'd0, t1}, 32'd0);
    chk("rst_t2", {16'd0, t2}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", {31'd0, valid}, 32'd0);
      chk("idle_busy0", {31'd0, busy}, 32'd0);
    end

    // Load R1 and R2, then an ADC-style instruction reading both
    run_instr(16'h2000, 16'h000A, 1'b0, 0);
    run_instr(16'h4000, 16'h0003, 1'b1, 0);
    instr       = 16'h284A;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("adc_not_yet", {31'd0, valid}, 32'd0);
    step();
    chk("adc_ir", {16'd0, ir}, 32'h284A);
    chk("adc_t1", {16'd0, t1}, 32'h000A);
    chk("adc_t2", {16'd0, t2}, 32'h0003);
    chk("adc_carry", {31'd0, carry}, 32'd1);
    expect_issue("adc", 16'h284A);
    accept(16'h284A, 5);
    writeback(16'h284A, 16'h000E, 1'b0);

    // R0 writes discarded; rd=0, rs=0 reads zero
    run_instr(16'h0123, 16'hFFFF, 1'b1, 1);
    instr       = 16'h0055;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("r0_t1", {16'd0, t1}, 32'd0);
    chk("r0_t2", {16'd0, t2}, 32'd0);
    accept(16'h0055, 0);
    writeback(16'h0055, 16'h1234, 1'b0);

    // Queue full while waiting for writeback
    wa = 16'h6C00;
    instr       = wa;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    expect_issue("qa", wa);
    accept(wa, 0);
    w1 = 16'hA411;
    w2 = 16'hC822;
    w3 = 16'hE033;
    instr       = w1;
    instr_valid = 1'b1;
    chk("qf_rdy1", {31'd0, instr_ready}, 32'd1);
    step();
    instr = w2;
    chk("qf_rdy2", {31'd0, instr_ready}, 32'd1);
    step();
    instr = w3;
    chk("qf_rdy3", {31'd0, instr_ready}, 32'd0);
    step();
    chk("qf_rdy3b", {31'd0, instr_ready}, 32'd0);
    chk("qf_busy", {31'd0, busy}, 32'd1);
    writeback(wa, 16'h5A5A, 1'b1);
    chk("qf_rdy_after_wb", {31'd0, instr_ready}, 32'd0);
    chk("qf_valid_after_wb", {31'd0, valid}, 32'd0);
    step();
    expect_issue("qf_w1", w1);
    chk("qf_rdy_after_pop", {31'd0, instr_ready}, 32'd1);
    step();
    instr_valid = 1'b0;
    chk("qf_rdy_refull", {31'd0, instr_ready}, 32'd0);
    expect_issue("qf_w1b", w1);
    accept(w1, 0);
    writeback(w1, 16'h0F0F, 1'b0);
    chk("qf_gap", {31'd0, valid}, 32'd0);
    step();
    expect_issue("qf_w2", w2);
    accept(w2, 1);
    writeback(w2, 16'hBEEF, 1'b1);
    step();
    expect_issue("qf_w3", w3);
    accept(w3, 0);
    writeback(w3, 16'h7777, 1'b0);
    chk("qf_drained", {31'd0, busy}, 32'd0);

    // Randomised instructions against the model
    for (int n = 0; n < 12; n++) begin
      run_instr(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
    end

    // Reset in WAIT_WB with two queued words
    instr       = 16'hE400;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    expect_issue("mr", 16'hE400);
    accept(16'hE400, 0);
    instr       = 16'h2C00;
    instr_valid = 1'b1;
    step();
    instr = 16'h4C00;
    step();
    instr_valid = 1'b0;
    chk("mr_full", {31'd0, instr_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, instr_ready}, 32'd1);
    chk("mr_ir", {16'd0, ir}, 32'd0);
    chk("mr_t1", {16'd0, t1}, 32'd0);
    model_reset();
    step();
    rst_n    = 1'b1;
    wb_valid = 1'b1;
    wb_data  = 16'hFFFF;
    wb_carry = 1'b1;
    step();
    wb_valid = 1'b0;
    chk("mr_late_wb_valid", {31'd0, valid}, 32'd0);
    chk("mr_late_wb_busy", {31'd0, busy}, 32'd0);
    run_instr(16'hEC00, 16'h0001, 1'b0, 0);
    run_instr(16'h3000, 16'h0002, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
